key_schedule_encrypt: RTL
=========================

// Module: key_schedule_encrypt
// PURPOSE
//  Forward SPECK128/128 key expansion: loads a 128-bit master key and emits one
//  round key per cycle for rounds 0..ROUNDS-1 through a valid/index stream.
//  Ends with the final (l,k) pair on outKey; key_schedule_decrypt runs from that pair.
//  Sits between the key register and the encrypt round datapath.
// PARAMETERS
//  WORD_W  64  word width n (k and l words)
//  ROUNDS  32  number of round keys emitted
//  ALPHA   8   right-rotate amount applied to l
//  BETA    3   left-rotate amount applied to k
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        synchronous reset, active-high
//  signal_start   in   1        start request, sampled only in IDLE
//  key            in   2*WORD_W {l0,k0}: k0=key[63:0], l0=key[127:64]
//  round_key      out  WORD_W   current round key k_i
//  rk_index       out  5        round number i of round_key
//  rk_valid       out  1        round_key/rk_index valid this cycle
//  outKey         out  2*WORD_W final {l,k} for round ROUNDS-1
//  finished       out  1        one-cycle pulse when outKey is updated
//  state_response out  4        current FSM state encoding
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge, any state): state=IDLE, rk_valid=0, finished=0,
//    rk_index=0, round_key=0, outKey=0, internal k/l cleared. Any run in progress is
//    aborted; no partial outKey update.
//  - FSM encodings: IDLE=0, LOAD=1, ROUND=2, DONE=3.
//  - IDLE: finished=0, rk_valid=0. signal_start=1 -> LOAD. Start is ignored outside IDLE.
//  - LOAD (1 cycle): k<=key[63:0], l<=key[127:64], i<=0 -> ROUND. The key is sampled here.
//  - ROUND: rk_valid=1, round_key=k, rk_index=i. On each accepted cycle (see CONFIG):
//      if i<ROUNDS-1: l<=(k + ROR(l,ALPHA)) ^ i (i zero-extended); k<=ROL(k,BETA) ^ l_new;
//      i<=i+1; remain in ROUND.
//      if i==ROUNDS-1: no k/l update -> DONE.
//  - Arithmetic: the addition is modulo 2^WORD_W with carry discarded; rotates are
//    circular over WORD_W bits.
//  - DONE (1 cycle): outKey<={l,k}, finished=1, rk_valid=0 -> IDLE.
//  - Latency: start in cycle 0; round 0 is valid from cycle 2; finished in cycle
//    ROUNDS+2 when there are no stalls.
//  - Back-to-back: start may be reasserted on the cycle after finished. outKey holds
//    until the next DONE.
// CONFIGURATION
//  KEY_SCHED_STALL_EN defined:
//    - Adds input rk_ready (1 bit).
//    - A ROUND cycle is accepted only when rk_valid & rk_ready.
//    - While rk_ready=0: round_key, rk_index, k, l and i hold stable and rk_valid stays 1.
//  KEY_SCHED_STALL_EN undefined:
//    - No rk_ready port. Every ROUND cycle is accepted and one key is emitted per cycle.
// TESTING
//  1 key=0f0e0d0c0b0a0908_0706050403020100, start pulse ->
//    rk0=0706050403020100, rk1=37253b31171d0309; 32 keys match the C model; finished at cycle 34.
//  2 Run the same key, then feed outKey to key_schedule_decrypt ->
//    recovered keys equal rk31..rk0 in reverse order.
//  3 Assert rst during ROUND at i=10 -> next cycle state_response=0, rk_valid=0,
//    outKey=0; a fresh start then reproduces test 1.
//  4 Hold signal_start=1 continuously ->
//    runs repeat with exactly one IDLE cycle between finished and the next LOAD.
//  5 [STALL_EN] rk_ready=0 for 5 cycles at i=3 ->
//    rk_index=3 and round_key are stable throughout; the sequence is unchanged; finished is delayed by 5.
//  6 key=all-ones -> the addition wraps without carry; keys match the model; rk_index wraps 0..31 only.

Source files
------------

// File: rtl/key_schedule_encrypt.sv
// Forward SPECK128/128 key expansion: one round key per cycle, final {l,k} on outKey.
// Optional KEY_SCHED_STALL_EN adds an rk_ready back-pressure input.
module key_schedule_encrypt #(
  parameter int WORD_W = 64,
  parameter int ROUNDS = 32,
  parameter int ALPHA  = 8,
  parameter int BETA   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signal_start,
  input  logic [2*WORD_W-1:0] key,
`ifdef KEY_SCHED_STALL_EN
  input  logic                rk_ready,
`endif
  output logic [WORD_W-1:0]   round_key,
  output logic [4:0]          rk_index,
  output logic                rk_valid,
  output logic [2*WORD_W-1:0] outKey,
  output logic                finished,
  output logic [3:0]          state_response
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    ROUND = 4'd2,
    DONE  = 4'd3
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0]   k, l;
  logic [WORD_W-1:0]   k_nxt, l_nxt;
  logic [4:0]          i;
  logic [2*WORD_W-1:0] out_key;
  logic                accept;
  logic                last;

  function automatic logic [WORD_W-1:0] ror_a(
    input logic [WORD_W-1:0] x
  );
    return (x >> ALPHA) | (x << (WORD_W - ALPHA));
  endfunction

  function automatic logic [WORD_W-1:0] rol_b(
    input logic [WORD_W-1:0] x
  );
    return (x << BETA) | (x >> (WORD_W - BETA));
  endfunction

`ifdef KEY_SCHED_STALL_EN
  assign accept = rk_ready;
`else
  assign accept = 1'b1;
`endif

  assign last = (i == 5'(ROUNDS - 1));

  // carry out of the add is dropped by the WORD_W-wide sum
  always_comb begin
    l_nxt = (k + ror_a(l)) ^ WORD_W'(i);
    k_nxt = rol_b(k) ^ l_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (signal_start) state_nxt = LOAD;
      LOAD:    state_nxt = ROUND;
      ROUND:   if (accept && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // outKey is captured on entry to DONE so it is valid while finished is high
  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      l       <= '0;
      i       <= '0;
      out_key <= '0;
    end else begin
      case (state)
        LOAD: begin
          k <= key[WORD_W-1:0];
          l <= key[2*WORD_W-1:WORD_W];
          i <= '0;
        end
        ROUND: begin
          if (accept) begin
            if (!last) begin
              k <= k_nxt;
              l <= l_nxt;
              i <= i + 5'd1;
            end else begin
              out_key <= {l, k};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rk_valid       = (state == ROUND);
  assign finished       = (state == DONE);
  assign round_key      = rk_valid ? k : '0;
  assign rk_index       = rk_valid ? i : '0;
  assign outKey         = out_key;
  assign state_response = state;

endmodule
